fifo_ctrl: RTL and testbench
============================

// Module: fifo_ctrl
// PURPOSE
//   Single-clock FIFO controller that sequences one fifomem instance.
//   - Owns the write/read pointers and drives the memory's write address, write enable and read address.
//   - Presents valid/ready handshakes on both sides.
//   - Read side is first-word-fall-through through a 1-entry registered output stage.
//   - Buffers pixel/command bytes between the SPI-side producer and the memory-LCD line engine.
// PARAMETERS
//   DATA_WIDTH  8                     data word width
//   ADDR_WIDTH  4                     memory address bits
//   FIFO_DEPTH  (1<<ADDR_WIDTH)       memory entries; must equal 2**ADDR_WIDTH
//   AFULL_LVL   FIFO_DEPTH-2          o_almost_full asserts when o_count >= AFULL_LVL
// PORTS
//   i_clk          in   1              single clock, rising edge
//   i_rst          in   1              reset, synchronous, active-high
//   i_flush        in   1              synchronous clear of all contents
//   i_wdata        in   DATA_WIDTH     write data
//   i_wvalid       in   1              write request
//   o_wready       out  1              write accepted when i_wvalid & o_wready
//   o_rdata        out  DATA_WIDTH     head-of-FIFO data (registered)
//   o_rvalid       out  1              o_rdata holds a valid word
//   i_rready       in   1              consumer pops when o_rvalid & i_rready
//   o_count        out  ADDR_WIDTH+1   words held (memory + output stage), 0..FIFO_DEPTH+1
//   o_almost_full  out  1              o_count >= AFULL_LVL
//   o_overflow     out  1              sticky: i_wvalid seen while o_wready==0
// BEHAVIOUR
//   Reset (i_rst=1 at edge)
//   - wptr=rptr=0, o_rvalid=0, o_rdata=0, o_count=0, o_overflow=0.
//   - o_wready=1, o_almost_full=0 (if AFULL_LVL>0).
//   Pointers
//   - wptr and rptr are ADDR_WIDTH+1 bits with a wrap bit; memory address = low ADDR_WIDTH bits.
//   - mem_used = wptr-rptr (mod 2**(ADDR_WIDTH+1)).
//   - mem_full  = mem_used==FIFO_DEPTH; mem_empty = wptr==rptr.
//   Write side
//   - o_wready = !mem_full (combinational from registered pointers).
//   - wr = i_wvalid & o_wready drives fifomem i_wclken; i_waddr=wptr[ADDR_WIDTH-1:0]; wptr+=1.
//   Read side (FWFT)
//   - fifomem i_raddr = rptr[ADDR_WIDTH-1:0], read combinationally.
//   - load = !mem_empty & (!o_rvalid | i_rready).
//   - On load: o_rdata <= mem data, o_rvalid <= 1, rptr+=1.
//   - Pop without load: o_rvalid <= 0; o_rdata holds its last value.
//   Latency
//   - Word written at edge N into an empty FIFO: o_rvalid=1 after edge N+1.
//   - No bypass of the memory.
//   Count
//   - o_count = mem_used + o_rvalid (combinational).
//   - Max is FIFO_DEPTH+1: memory full plus output stage held.
//   Boundaries
//   - Simultaneous write and read when full: the pop frees the output stage and load refills it,
//     so the memory drops to FIFO_DEPTH-1 after that edge. o_wready still reflects the
//     pre-edge full state, so the write is refused in that cycle.
//   - Write into an empty memory in the same cycle as a pop: the pop completes, o_rvalid drops
//     for one cycle, then reloads.
//   - Pointer wrap: the wrap bit toggles and must give a correct mem_used across 2**(ADDR_WIDTH+1).
//   Errors
//   - Overflow: i_wvalid & !o_wready sets o_overflow; the write is dropped and the pointers
//     are unchanged. Cleared only by i_rst or i_flush.
//   Flush and priority
//   - i_flush has the same effect as reset, excluding memory contents.
//   - i_flush beats any write or read in the same cycle.
//   - Mid-operation reset or flush discards in-flight words; no handshake completes on that edge.
//   - Memory contents are never cleared; stale data is unobservable while o_rvalid=0.
// STRUCTURE
//   - Sub-module: one fifomem instance (DATA_WIDTH, ADDR_WIDTH, FIFO_DEPTH passed through);
//     its i_wclk is tied to i_clk.
//   - Shared package: none needed; pointer width ADDR_WIDTH+1 is a localparam.
//   - Pointer, full/empty and FWFT logic all live in this module; no further sub-modules.
// TESTING
//   1. Reset then 1 write 0xA5 -> o_rvalid=1 two edges after the write; o_rdata=0xA5; o_count=1.
//   2. Fill with i_rready=0 (DEPTH=16): 17 words accepted, o_wready=0 and o_count=17;
//      the 18th write is dropped and o_overflow=1.
//   3. Full FIFO with i_wvalid=1 and i_rready=1 -> the pop completes; o_wready rises one edge
//      later; data order preserved.
//   4. Streaming 100 words with random valid/ready -> output equals the input sequence;
//      pointers wrap many times; o_count never exceeds 17.
//   5. i_flush asserted with o_count=9 and a write pending -> next cycle o_count=0, o_rvalid=0,
//      o_overflow=0; the pending write is discarded.
//   6. i_rst asserted mid-stream with o_rvalid=1 -> all outputs return to reset values
//      after one edge.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults for the FIFO controller slice.
// Sized for the SPI-to-memory-LCD byte buffer.
package fifo_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

endpackage

// File: rtl/fifo_ctrl_fifomem.sv
// Simple dual-port storage array for the FIFO.
// Registered write port, combinational read port.
module fifomem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 1 << ADDR_WIDTH
) (
  input  logic                  i_wclk,
  input  logic                  i_wclken,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // Store a word on each enabled write edge
  always_ff @(posedge i_wclk) begin
    if (i_wclken) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller with FWFT output stage.
// Owns pointers and sequences one fifomem instance.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 1 << ADDR_WIDTH,
  parameter int AFULL_LVL  = FIFO_DEPTH - 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_almost_full,
  output logic                  o_overflow
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         mem_used;
  logic                  mem_full;
  logic                  mem_empty;
  logic                  wr;
  logic                  ld;
  logic                  pop;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Wrap bit keeps full and empty distinct
  assign mem_used  = wptr - rptr;
  assign mem_full  = (mem_used == PW'(FIFO_DEPTH));
  assign mem_empty = (wptr == rptr);

  assign o_wready = !mem_full;
  assign wr       = i_wvalid && o_wready;
  assign pop      = o_rvalid && i_rready;
  assign ld       = !mem_empty && (!o_rvalid || i_rready);

  assign o_count       = mem_used + PW'(o_rvalid);
  assign o_almost_full = (int'(o_count) >= AFULL_LVL);

  fifomem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_mem (
    .i_wclk   (i_clk),
    .i_wclken (wr),
    .i_waddr  (wptr[ADDR_WIDTH-1:0]),
    .i_wdata  (i_wdata),
    .i_raddr  (rptr[ADDR_WIDTH-1:0]),
    .o_rdata  (mem_rdata)
  );

  // Pointers, output stage and sticky overflow
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wptr       <= '0;
      rptr       <= '0;
      o_rvalid   <= 1'b0;
      o_rdata    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
      end
      if (ld) begin
        rptr     <= rptr + 1'b1;
        o_rdata  <= mem_rdata;
        o_rvalid <= 1'b1;
      end else if (pop) begin
        o_rvalid <= 1'b0;
      end
      if (i_wvalid && !o_wready) begin
        o_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl.
// Directed table plus multi-cycle sequences.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] wdata;
  logic       wvalid;
  logic       wready;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic [4:0] count;
  logic       afull;
  logic       ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_flush       (flush),
    .i_wdata       (wdata),
    .i_wvalid      (wvalid),
    .o_wready      (wready),
    .o_rdata       (rdata),
    .o_rvalid      (rvalid),
    .i_rready      (rready),
    .o_count       (count),
    .o_almost_full (afull),
    .o_overflow    (ovf)
  );

  typedef struct {
    logic       rst;
    logic       flush;
    logic       wvalid;
    logic [7:0] wdata;
    logic       rready;
    logic       e_wready;
    logic       e_rvalid;
    logic [7:0] e_rdata;
    int         e_count;
    logic       e_af;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; wvalid = 0; rready = 0; wdata = 8'h00;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wready"}, int'(wready), 1);
    chk({tag, "_rvalid"}, int'(rvalid), 0);
    chk({tag, "_rdata"}, int'(rdata), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_af"}, int'(afull), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
  endtask

  byte unsigned q[$];
  byte unsigned src[100];

  initial begin
    idle();
    rst = 1;

    // rst fl wv data  rr  wrdy rv rdata cnt af ovf
    vecs[0] = '{1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0};
    vecs[1] = '{0, 0, 1, 8'hA5, 0, 1, 0, 8'h00, 1, 0, 0};
    vecs[2] = '{0, 0, 0, 8'h00, 0, 1, 1, 8'hA5, 1, 0, 0};
    vecs[3] = '{0, 0, 1, 8'h11, 1, 1, 0, 8'hA5, 1, 0, 0};
    vecs[4] = '{0, 0, 0, 8'h00, 0, 1, 1, 8'h11, 1, 0, 0};
    vecs[5] = '{0, 0, 0, 8'h00, 1, 1, 0, 8'h11, 0, 0, 0};

    for (int i = 0; i < 6; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      rst = vecs[i].rst;
      flush = vecs[i].flush;
      wvalid = vecs[i].wvalid;
      wdata = vecs[i].wdata;
      rready = vecs[i].rready;
      step();
      chk({t, "_wready"}, int'(wready), int'(vecs[i].e_wready));
      chk({t, "_rvalid"}, int'(rvalid), int'(vecs[i].e_rvalid));
      chk({t, "_rdata"}, int'(rdata), int'(vecs[i].e_rdata));
      chk({t, "_count"}, int'(count), vecs[i].e_count);
      chk({t, "_af"}, int'(afull), int'(vecs[i].e_af));
      chk({t, "_ovf"}, int'(ovf), int'(vecs[i].e_ovf));
    end
    idle();

    // Fill: 17 words accepted with consumer stalled
    for (int i = 0; i < 17; i++) begin
      wvalid = 1;
      wdata = 8'(8'h20 + i);
      chk($sformatf("fill_wready%0d", i), int'(wready), 1);
      step();
    end
    chk("fill_count", int'(count), 17);
    chk("fill_wready_low", int'(wready), 0);
    chk("fill_af", int'(afull), 1);
    chk("fill_ovf_clear", int'(ovf), 0);
    chk("fill_head", int'(rdata), 8'h20);
    wdata = 8'hEE;
    step();
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_count", int'(count), 17);

    // Full with write and pop together: write refused
    wvalid = 1;
    wdata = 8'h99;
    rready = 1;
    step();
    chk("fullrw_count", int'(count), 16);
    chk("fullrw_wready", int'(wready), 1);
    chk("fullrw_head", int'(rdata), 8'h21);
    chk("fullrw_rvalid", int'(rvalid), 1);
    wvalid = 0;
    begin
      int got;
      got = 0;
      for (int c = 0; c < 40 && got < 16; c++) begin
        if (rvalid) begin
          chk($sformatf("drain%0d", got), int'(rdata), 8'h21 + got);
          got++;
        end
        step();
      end
      chk("drain_words", got, 16);
    end
    chk("drain_count", int'(count), 0);
    chk("drain_ovf_sticky", int'(ovf), 1);
    idle();

    // Flush with 9 held and a write pending
    for (int i = 0; i < 9; i++) begin
      wvalid = 1;
      wdata = 8'(8'h40 + i);
      step();
    end
    chk("preflush_count", int'(count), 9);
    flush = 1;
    wdata = 8'h77;
    step();
    chk_reset_state("flush");
    idle();
    step();
    chk("postflush_count", int'(count), 0);
    chk("postflush_rvalid", int'(rvalid), 0);

    // Reset mid-stream with output valid
    for (int i = 0; i < 3; i++) begin
      wvalid = 1;
      wdata = 8'(8'h60 + i);
      step();
    end
    wvalid = 0;
    chk("prerst_rvalid", int'(rvalid), 1);
    rst = 1;
    wvalid = 1;
    rready = 1;
    wdata = 8'h55;
    step();
    chk_reset_state("rst");
    idle();
    step();
    chk("postrst_count", int'(count), 0);

    // Random streaming against a queue scoreboard
    for (int i = 0; i < 100; i++) src[i] = 8'($urandom);
    begin
      int sent;
      int rcvd;
      int maxc;
      bit w;
      bit p;
      sent = 0;
      rcvd = 0;
      maxc = 0;
      for (int c = 0; c < 3000 && rcvd < 100; c++) begin
        wvalid = (sent < 100) && ($urandom_range(0, 3) != 0);
        wdata = wvalid ? src[sent] : 8'h00;
        rready = ($urandom_range(0, 3) < ((c < 150) ? 1 : 3));
        w = wvalid && wready;
        p = rvalid && rready;
        if (p) begin
          if (q.size() == 0) begin
            chk("stream_underrun", 1, 0);
          end else begin
            chk($sformatf("stream%0d", rcvd), int'(rdata), int'(q.pop_front()));
          end
          rcvd++;
        end
        if (w) begin
          q.push_back(src[sent]);
          sent++;
        end
        step();
        if (int'(count) != q.size()) begin
          chk($sformatf("stream_count_c%0d", c), int'(count), q.size());
        end
        if (int'(count) > maxc) maxc = int'(count);
      end
      chk("stream_rcvd", rcvd, 100);
      chk("stream_max_le17", int'(maxc <= 17), 1);
      chk("stream_end_count", int'(count), 0);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
